// File: rtl/vr_rr_arbiter.sv
// vr_rr_arbiter: packet-aware round-robin arbiter.
// NUM_REQ valid/ready requesters share one registered downstream port.
// A packet that starts with a non-last beat locks the grant until its last beat.
// After each packet, priority rotates to the requester just past the winner.
module vr_rr_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ*WIDTH-1:0] up_data,
  input  logic [NUM_REQ-1:0]       up_valid,
  input  logic [NUM_REQ-1:0]       up_last,
  output logic [NUM_REQ-1:0]       up_ready,
  output logic [WIDTH-1:0]         down_data,
  output logic [ID_W-1:0]          down_id,
  output logic                     down_last,
  output logic                     down_valid,
  input  logic                     down_ready,
  output logic                     busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              down_valid_q, down_valid_d;
  logic [WIDTH-1:0]  down_data_q, down_data_d;
  logic [ID_W-1:0]   down_id_q, down_id_d;
  logic              down_last_q, down_last_d;

  logic [WIDTH-1:0]  up_data_arr [NUM_REQ];
  logic              load_ok;
  logic [ID_W:0]     cand;
  logic [ID_W-1:0]   win_idx;
  logic              win_found;
  logic [ID_W-1:0]   sel;
  logic [ID_W-1:0]   sel_inc;
  logic              up_xfer;

  // Split the flat data bus into one word per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_split
    assign up_data_arr[gi] = up_data[gi*WIDTH +: WIDTH];
  end

  // The output register can accept a beat when empty or draining this cycle.
  assign load_ok = !down_valid_q || down_ready;

  // Rotating-priority search: first valid requester starting at ptr, wrapping.
  // Iterate from the farthest offset down so the nearest one wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (up_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Source whose beat may be accepted this cycle: search result or locked grant.
  assign sel     = (state_q == LOCKED) ? gnt_q : win_idx;
  assign sel_inc = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;

  // One-hot ready. In LOCKED it depends only on state and load_ok, never on up_valid.
  always_comb begin
    up_ready = '0;
    if (!rst) begin
      if (state_q == LOCKED) begin
        up_ready[gnt_q] = load_ok;
      end else if (win_found) begin
        up_ready[win_idx] = load_ok;
      end
    end
  end

  assign up_xfer = |(up_valid & up_ready);

  // Next-state: output register load/drain, packet lock and priority rotation.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    ptr_d        = ptr_q;
    down_valid_d = down_valid_q;
    down_data_d  = down_data_q;
    down_id_d    = down_id_q;
    down_last_d  = down_last_q;

    if (down_valid_q && down_ready) begin
      down_valid_d = 1'b0;
    end

    if (up_xfer) begin
      down_valid_d = 1'b1;
      down_data_d  = up_data_arr[sel];
      down_id_d    = sel;
      down_last_d  = up_last[sel];
      if (up_last[sel]) begin
        state_d = IDLE;
        ptr_d   = sel_inc;
      end else begin
        state_d = LOCKED;
        gnt_d   = sel;
      end
    end
  end

  // State and output registers; reset discards any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      ptr_q        <= '0;
      down_valid_q <= 1'b0;
      down_data_q  <= '0;
      down_id_q    <= '0;
      down_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      ptr_q        <= ptr_d;
      down_valid_q <= down_valid_d;
      down_data_q  <= down_data_d;
      down_id_q    <= down_id_d;
      down_last_q  <= down_last_d;
    end
  end

  assign down_valid = down_valid_q;
  assign down_data  = down_data_q;
  assign down_id    = down_id_q;
  assign down_last  = down_last_q;
  assign busy       = (state_q == LOCKED);

endmodule

// File: doc/vr_rr_arbiter.md
VR_RR_ARBITER -- requirements
Module: vr_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width per beat.
REQ-002 SHALL have parameter NUM_REQ, default 4, legal range 2..8, meaning number of upstream requesters.
REQ-003 SHALL have parameter ID_W, default $clog2(NUM_REQ), meaning requester-index width.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port up_data  input  NUM_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port up_valid  input  NUM_REQ  per-requester valid.
REQ-008 SHALL have port up_last  input  NUM_REQ  per-requester end-of-packet flag, qualified by up_valid.
REQ-009 SHALL have port up_ready  output  NUM_REQ  per-requester ready.
REQ-010 SHALL have port down_data  output  WIDTH  registered data to downstream.
REQ-011 SHALL have port down_id  output  ID_W  index of the source requester of the current down beat.
REQ-012 SHALL have port down_last  output  1  registered end-of-packet flag.
REQ-013 SHALL have port down_valid  output  1  registered valid to downstream.
REQ-014 SHALL have port down_ready  input  1  downstream ready.
REQ-015 SHALL have port busy  output  1  high while a packet is locked (state LOCKED).

Function
REQ-016 SHALL treat an up beat from i as transferred when up_valid[i] & up_ready[i], and a down beat as transferred when down_valid & down_ready.
REQ-017 SHALL hold a single-entry output register; load_ok = !down_valid | down_ready.
REQ-018 SHALL implement FSM states IDLE and LOCKED, plus grant register gnt (ID_W) and priority pointer ptr (ID_W).
REQ-019 SHALL in IDLE select winner = first index with up_valid set, searching ptr, ptr+1, ... modulo NUM_REQ; none if all valid low.
REQ-020 SHALL in IDLE drive up_ready[winner] = load_ok and all other up_ready bits 0; all bits 0 when no winner.
REQ-021 SHALL in LOCKED drive up_ready[gnt] = load_ok and all other bits 0, ignoring other requesters' valid.
REQ-022 SHALL never assert more than one up_ready bit in a cycle, and up_ready SHALL not depend combinationally on up_valid of the granted requester in LOCKED.
REQ-023 SHALL on an up transfer from i load down_data, down_last, down_id=i and set down_valid=1 in the next cycle (latency 1 cycle).
REQ-024 SHALL on a down transfer with no up transfer in the same cycle clear down_valid; simultaneous down and up transfers SHALL keep down_valid=1 with new contents (full throughput, 1 beat/cycle).
REQ-025 SHALL hold down_data/down_id/down_last stable while down_valid=1 and down_ready=0.
REQ-026 SHALL transition IDLE->LOCKED, gnt<=i, when a beat with up_last=0 transfers from i.
REQ-027 SHALL remain in IDLE when a beat with up_last=1 transfers (single-beat packet) and set ptr<=(i+1) mod NUM_REQ.
REQ-028 SHALL transition LOCKED->IDLE and set ptr<=(gnt+1) mod NUM_REQ when a beat with up_last=1 transfers from gnt.
REQ-029 SHALL wrap ptr from NUM_REQ-1 to 0.
REQ-030 SHALL drive busy = (state==LOCKED).

Reset
REQ-031 SHALL on rst=1 asynchronously force state=IDLE, gnt=0, ptr=0, down_valid=0, down_data=0, down_id=0, down_last=0, busy=0; up_ready SHALL evaluate to all 0 as the output register is empty only after release (up_ready follows REQ-020 from the first cycle after deassertion).
REQ-032 SHALL on reset mid-packet discard the locked packet and the output register; no partial beat SHALL appear after deassertion.

Verification
REQ-033 SHALL cover: after reset, up_valid=4'b1111, all up_last=1, down_ready=1 -> down_id sequence 0,1,2,3,0 on consecutive cycles, one beat per cycle.
REQ-034 SHALL cover: requester 2 sends 3-beat packet (last on beat 3) while requester 0 valid continuously -> down_id 2,2,2 then 0; up_ready[0]=0 throughout the packet; busy high from cycle after beat 1 until cycle after beat 3.
REQ-035 SHALL cover: down_ready=0 for 5 cycles with down_valid=1 -> down_data/down_id/down_last constant, all up_ready=0; on down_ready=1 next beat follows with no gap.
REQ-036 SHALL cover: only requester 3 valid with ptr=3, single-beat packet -> ptr becomes 0 (wrap); next contention between 1 and 3 grants 1.
REQ-037 SHALL cover: rst asserted mid-packet (LOCKED, down_valid=1) -> outputs zero immediately, busy=0, next grant from ptr=0.
